// File: rtl/count_ctrl_frontend.sv
// Direction/step front-end for the even up/down counter.
// A raw push-button is synchronized and debounced; each accepted press flips
// CountUp and raises DirPulse for one cycle. A free-running divider provides a
// one-cycle StepTick enable so the counter advances in the Clk domain.
module count_ctrl_frontend #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int TICK_DIV        = 50000000
) (
    input  logic Clk,
    input  logic Rst,
    input  logic BtnDir,
    output logic CountUp,
    output logic DirPulse,
    output logic StepTick
);

    // Counter widths; clamp to 1 bit so tiny parameters still elaborate.
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    // Terminal values: counters stop (debounce) or wrap (tick) here.
    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] T_LAST = TW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_HIGH = 2'd1,
        PRESSED   = 2'd2,
        WAIT_LOW  = 2'd3
    } state_t;

    logic          s1;
    logic          s2;
    state_t        state;
    logic [DW-1:0] dcnt;
    logic [TW-1:0] tcnt;

    // Two-flop synchronizer for the asynchronous button input.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= BtnDir;
            s2 <= s1;
        end
    end

    // Debounce FSM: a level must hold for DEBOUNCE_CYCLES samples to be
    // accepted; only an accepted press flips the direction.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state    <= IDLE;
            dcnt     <= '0;
            CountUp  <= 1'b1;
            DirPulse <= 1'b0;
        end else begin
            DirPulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (s2) begin
                        state <= WAIT_HIGH;
                        dcnt  <= '0;
                    end
                end
                WAIT_HIGH: begin
                    if (!s2) begin
                        state <= IDLE;
                    end else if (dcnt == D_LAST) begin
                        state    <= PRESSED;
                        CountUp  <= ~CountUp;
                        DirPulse <= 1'b1;
                    end else begin
                        dcnt <= dcnt + 1'b1;
                    end
                end
                PRESSED: begin
                    // Holding the button never re-toggles.
                    if (!s2) begin
                        state <= WAIT_LOW;
                        dcnt  <= '0;
                    end
                end
                WAIT_LOW: begin
                    if (s2) begin
                        state <= PRESSED;
                    end else if (dcnt == D_LAST) begin
                        state <= IDLE;
                    end else begin
                        dcnt <= dcnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    dcnt  <= '0;
                end
            endcase
        end
    end

    // Free-running step divider, wraps at TICK_DIV-1.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            tcnt <= '0;
        end else if (tcnt == T_LAST) begin
            tcnt <= '0;
        end else begin
            tcnt <= tcnt + 1'b1;
        end
    end

    // Step enable decoded straight from the divider register.
    assign StepTick = (tcnt == T_LAST);

endmodule

// File: tb/tb_count_ctrl_frontend.sv
// Directed bench for count_ctrl_frontend with DEBOUNCE_CYCLES=4, TICK_DIV=5.
// All observations are taken on the falling edge; "edge e" is the e-th
// rising edge after reset release.
module tb_count_ctrl_frontend;

    localparam int N  = 4;
    localparam int TD = 5;

    logic Clk;
    logic Rst;
    logic BtnDir;
    logic CountUp;
    logic DirPulse;
    logic StepTick;

    int tests;
    int fails;
    int ticks;

    // Downstream even up/down counter driven by the front-end outputs.
    logic [2:0] cnt;

    count_ctrl_frontend #(
        .DEBOUNCE_CYCLES(N),
        .TICK_DIV(TD)
    ) dut (
        .Clk(Clk),
        .Rst(Rst),
        .BtnDir(BtnDir),
        .CountUp(CountUp),
        .DirPulse(DirPulse),
        .StepTick(StepTick)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk or posedge Rst) begin
        if (Rst) cnt <= 3'd0;
        else if (StepTick) cnt <= CountUp ? cnt + 3'd2 : cnt - 3'd2;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic adv(input int n);
        repeat (n) @(negedge Clk);
    endtask

    // Reset asserted and released on a falling edge.
    task automatic do_reset();
        Rst = 1'b1;
        adv(2);
        Rst = 1'b0;
    endtask

    initial begin
        logic [2:0] exp_cnt [0:11];
        exp_cnt = '{3'd0, 3'd2, 3'd4, 3'd6, 3'd0, 3'd2, 3'd4, 3'd6,
                    3'd4, 3'd2, 3'd0, 3'd6};
        tests  = 0;
        fails  = 0;
        ticks  = 0;
        BtnDir = 1'b0;
        Rst    = 1'b1;

        // Reset state
        adv(2);
        chk("rst_countup", {7'd0, CountUp}, 8'd1);
        chk("rst_dirpulse", {7'd0, DirPulse}, 8'd0);
        chk("rst_steptick", {7'd0, StepTick}, 8'd0);
        Rst = 1'b0;
        chk("rel_steptick", {7'd0, StepTick}, 8'd0);

        // Clean press sampled from edge 10, tick cadence checked alongside
        for (int e = 1; e <= 50; e++) begin
            adv(1);
            if (StepTick) ticks++;
            chk("cad_steptick", {7'd0, StepTick}, {7'd0, (e % TD) == TD - 1});
            chk("press_countup", {7'd0, CountUp}, {7'd0, e < 16});
            chk("press_dirpulse", {7'd0, DirPulse}, {7'd0, e == 16});
            if (e == 9) BtnDir = 1'b1;
        end
        chk("cad_tick_total", 8'(ticks), 8'd10);

        // Holding the button never re-toggles
        for (int i = 0; i < 100; i++) begin
            adv(1);
            chk("hold_countup", {7'd0, CountUp}, 8'd0);
            chk("hold_dirpulse", {7'd0, DirPulse}, 8'd0);
        end

        // Release with a 2-cycle glitch inside WAIT_LOW: no toggle
        for (int i = 0; i < 25; i++) begin
            BtnDir = (i == 3 || i == 4);
            adv(1);
            chk("relglitch_countup", {7'd0, CountUp}, 8'd0);
            chk("relglitch_dirpulse", {7'd0, DirPulse}, 8'd0);
        end

        // Clean press after full release toggles back to up
        BtnDir = 1'b1;
        adv(6);
        chk("press2_pre_countup", {7'd0, CountUp}, 8'd0);
        chk("press2_pre_dirpulse", {7'd0, DirPulse}, 8'd0);
        adv(1);
        chk("press2_countup", {7'd0, CountUp}, 8'd1);
        chk("press2_dirpulse", {7'd0, DirPulse}, 8'd1);
        adv(1);
        chk("press2_pulse_end", {7'd0, DirPulse}, 8'd0);

        // Full release, then bounce: 3 high / 2 low, five times
        BtnDir = 1'b0;
        adv(20);
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < 5; i++) begin
                BtnDir = (i < 3);
                adv(1);
                chk("bounce_countup", {7'd0, CountUp}, 8'd1);
                chk("bounce_dirpulse", {7'd0, DirPulse}, 8'd0);
            end
        end

        // Steady hold after the bounces gives one toggle on schedule
        BtnDir = 1'b1;
        adv(6);
        chk("press3_pre_countup", {7'd0, CountUp}, 8'd1);
        adv(1);
        chk("press3_countup", {7'd0, CountUp}, 8'd0);
        chk("press3_dirpulse", {7'd0, DirPulse}, 8'd1);
        adv(1);
        chk("press3_pulse_end", {7'd0, DirPulse}, 8'd0);

        // Reset while in WAIT_HIGH with dcnt=2 and CountUp=0
        BtnDir = 1'b0;
        adv(20);
        BtnDir = 1'b1;
        adv(5);
        chk("midrst_pre_countup", {7'd0, CountUp}, 8'd0);
        #2 Rst = 1'b1;
        #1;
        chk("midrst_countup", {7'd0, CountUp}, 8'd1);
        chk("midrst_dirpulse", {7'd0, DirPulse}, 8'd0);
        chk("midrst_steptick", {7'd0, StepTick}, 8'd0);
        adv(1);
        Rst = 1'b0;
        adv(6);
        chk("postrst_pre_countup", {7'd0, CountUp}, 8'd1);
        chk("postrst_pre_dirpulse", {7'd0, DirPulse}, 8'd0);
        adv(1);
        chk("postrst_countup", {7'd0, CountUp}, 8'd0);
        chk("postrst_dirpulse", {7'd0, DirPulse}, 8'd1);

        // Integration with the downstream counter; press toggles at edge 37
        BtnDir = 1'b0;
        do_reset();
        chk("int_cnt_e0", {5'd0, cnt}, {5'd0, exp_cnt[0]});
        for (int e = 1; e <= 55; e++) begin
            adv(1);
            if (e % TD == 0) chk("int_cnt", {5'd0, cnt}, {5'd0, exp_cnt[e / TD]});
            if (e == 30) BtnDir = 1'b1;
        end
        chk("int_countup", {7'd0, CountUp}, 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
